cshm_coef_decoder: RTL and testbench
====================================

Name: cshm_coef_decoder

Overview:
- Sequential, parametrised coefficient decoder for the CSHM FIR filter.
- Accepts one COEF_W-bit filter coefficient over a valid/ready handshake and splits it into GROUP_W-bit groups.
- Decodes one group per clock into:
  - a shift amount,
  - an odd-alphabet select index,
  - a zero flag.
- Presents all groups together on a packed, handshaked output that drives the shared-alphabet multiplier's select/shift stage.
- Optional signed mode decodes the magnitude and reports the sign separately.

Parameters:
- COEF_W, 8: coefficient width. Must be a multiple of GROUP_W.
- GROUP_W, 4: bits per group. Must be at least 2.
- SIGNED, 0: 1 = coef is two's complement; the decoder works on the magnitude and reports the sign.
- Derived NG = COEF_W/GROUP_W: number of groups.
- Derived SH_W = clog2(GROUP_W): shift field width.
- Derived SEL_W = GROUP_W-1: select field width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  coef is valid.
- in_ready  out  1  decoder can accept a coefficient.
- coef  in  COEF_W  coefficient.
- out_valid  out  1  decoded result is available.
- out_ready  in  1  consumer accepts the result.
- out_shift  out  NG*SH_W  per-group shift; group i at [i*SH_W +: SH_W]; group 0 = coef LSBs.
- out_select  out  NG*SEL_W  per-group odd-alphabet index, packed the same way.
- out_zero  out  NG  per-group flag, 1 = group is zero.
- out_sign  out  1  coefficient sign. Always 0 when SIGNED=0.

Behaviour:
- Reset (async assert): state = IDLE, group index = 0, every output register = 0, out_valid = 0, in_ready = 1 after reset. Reset mid-operation aborts the coefficient with no partial output.
- Per-group decode of value g:
  - g == 0: zero = 1, shift = 0, select = 0.
  - Otherwise: shift = number of trailing zeros of g (0..GROUP_W-1), odd = g >> shift, select = odd >> 1.
  - For GROUP_W=4: odd 1,3,5,…,15 gives select 0..7.
- Sign (SIGNED=1): sign = coef[MSB]; magnitude = two's-complement negation when negative, treated as an unsigned COEF_W value. Most-negative value: 0x80 gives magnitude 0x80.
- SIGNED=0: magnitude = coef, sign = 0.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready = 1. On in_valid at a clk edge, latch magnitude and sign, index = 0, go to BUSY. Clear all result fields on accept.
  - BUSY: in_ready = 0, out_valid = 0. Each cycle, decode group[index], write its fields, then index++. After group NG-1 is written, go to DONE.
  - DONE: out_valid = 1, outputs stable. On out_ready at a clk edge, go to IDLE; in_ready = 1 the next cycle.
- Latency: out_valid rises NG clocks after the accepting edge. Throughput: one coefficient per NG+2 cycles minimum.
- Handshake rules:
  - in_valid during BUSY/DONE is ignored; the source must hold it.
  - out_ready without out_valid has no effect.
  - Outputs change only on accept (clear) and during BUSY.
  - out_valid drops on the edge after the out_valid&out_ready handshake.
  - There is no IDLE/DONE overlap, so in_valid and out_ready both high in DONE accepts only the output.
- Index counter is log2-sized and wraps to 0 on entering DONE.

Test Plan:
1. COEF_W=8, GROUP_W=4, SIGNED=0; coef=0x4C, out_ready=1 -> out_valid exactly 2 clocks after accept; out_shift=4'b10_10, out_select=6'b000_001, out_zero=2'b00, out_sign=0.
2. coef=0x0F -> group0 shift=0, select=7; group1 zero=1, shift=0, select=0. out_shift=4'b00_00, out_select=6'b000_111, out_zero=2'b10.
3. SIGNED=1; coef=0xB4 (-76) -> magnitude 0x4C; out_sign=1; fields identical to scenario 1.
4. SIGNED=1; coef=0x80 -> group0 zero=1; group1 (0x8) shift=3, select=0; out_shift=4'b11_00, out_zero=2'b01, out_sign=1.
5. out_ready held low 5 cycles in DONE, in_valid held high -> out_valid and all fields stable, in_ready=0 throughout. When out_ready rises, out_valid drops next edge, in_ready=1, and the new coef is accepted the following edge.
6. reset pulsed during BUSY (after group 0 written) -> asynchronously all outputs 0, out_valid=0. After release, in_ready=1, and a fresh coef=0x4C yields scenario 1's result.

Source files
------------

// File: rtl/cshm_coef_decoder_if.sv
// Handshaked coefficient-in / decoded-groups-out bundle for the CSHM coefficient decoder.
// The decoder sits on the slave side; the coefficient source and result consumer sit on the master side.
interface cshm_coef_decoder_if #(
    parameter int COEF_W  = 8,
    parameter int GROUP_W = 4
);
    localparam int NG    = COEF_W / GROUP_W;
    localparam int SH_W  = $clog2(GROUP_W);
    localparam int SEL_W = GROUP_W - 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [COEF_W-1:0]     coef;
    logic                  out_valid;
    logic                  out_ready;
    logic [NG*SH_W-1:0]    out_shift;
    logic [NG*SEL_W-1:0]   out_select;
    logic [NG-1:0]         out_zero;
    logic                  out_sign;

    modport slave (
        input  in_valid, coef, out_ready,
        output in_ready, out_valid, out_shift, out_select, out_zero, out_sign
    );

    modport master (
        output in_valid, coef, out_ready,
        input  in_ready, out_valid, out_shift, out_select, out_zero, out_sign
    );
endinterface

// File: rtl/cshm_coef_decoder.sv
// Splits a coefficient into GROUP_W-bit groups, one group decoded per clock into shift/odd-select/zero.
// out_valid rises NG clocks after accept; result is held in DONE until out_ready, no new input until then.
module cshm_coef_decoder #(
    parameter int COEF_W  = 8,
    parameter int GROUP_W = 4,
    parameter int SIGNED  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    cshm_coef_decoder_if.slave     bus
);
    localparam int NG    = COEF_W / GROUP_W;
    localparam int SH_W  = $clog2(GROUP_W);
    localparam int SEL_W = GROUP_W - 1;
    localparam int IDX_W = (NG > 1) ? $clog2(NG) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q;
    logic [COEF_W-1:0]      mag_q;
    logic                   sign_q;
    logic [NG*SH_W-1:0]     shift_q;
    logic [NG*SEL_W-1:0]    select_q;
    logic [NG-1:0]          zero_q;

    logic                   sign_in;
    logic [COEF_W-1:0]      mag_in;
    logic [GROUP_W-1:0]     grp;
    logic [GROUP_W-1:0]     odd;
    logic [SH_W-1:0]        g_shift;
    logic [SEL_W-1:0]       g_sel;
    logic                   g_zero;
    logic                   found;
    logic                   last;

    // Most-negative input negates to itself, which is the correct unsigned magnitude.
    assign sign_in = (SIGNED != 0) && bus.coef[COEF_W-1];
    assign mag_in  = sign_in ? (~bus.coef + 1'b1) : bus.coef;
    assign last    = (idx_q == IDX_W'(NG - 1));

    always_comb begin
        grp     = mag_q[idx_q*GROUP_W +: GROUP_W];
        g_shift = '0;
        found   = 1'b0;
        for (int i = 0; i < GROUP_W; i++) begin
            if (!found && grp[i]) begin
                g_shift = SH_W'(i);
                found   = 1'b1;
            end
        end
        g_zero = !found;
        odd    = grp >> g_shift;
        g_sel  = odd[GROUP_W-1:1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = BUSY;
            BUSY:    if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            mag_q    <= '0;
            sign_q   <= 1'b0;
            shift_q  <= '0;
            select_q <= '0;
            zero_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    mag_q    <= mag_in;
                    sign_q   <= sign_in;
                    idx_q    <= '0;
                    shift_q  <= '0;
                    select_q <= '0;
                    zero_q   <= '0;
                end
                BUSY: begin
                    shift_q[idx_q*SH_W +: SH_W]    <= g_shift;
                    select_q[idx_q*SEL_W +: SEL_W] <= g_sel;
                    zero_q[idx_q]                  <= g_zero;
                    idx_q                          <= last ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_shift  = shift_q;
    assign bus.out_select = select_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_sign   = sign_q;
endmodule

// File: tb/tb_cshm_coef_decoder.sv
// Directed bench: an unsigned and a signed decoder run in lockstep on the same stimulus.
module tb_cshm_coef_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] coef = 8'h00;
    logic       out_ready = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    cshm_coef_decoder_if #(.COEF_W(8), .GROUP_W(4)) b0 ();
    cshm_coef_decoder_if #(.COEF_W(8), .GROUP_W(4)) b1 ();

    assign b0.in_valid  = in_valid;
    assign b0.coef      = coef;
    assign b0.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.coef      = coef;
    assign b1.out_ready = out_ready;

    cshm_coef_decoder #(.COEF_W(8), .GROUP_W(4), .SIGNED(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    cshm_coef_decoder #(.COEF_W(8), .GROUP_W(4), .SIGNED(1)) u1 (.clk(clk), .reset(reset), .bus(b1));

    // {sign, zero[1:0], select[5:0], shift[3:0]}
    wire [12:0] r0 = {b0.out_sign, b0.out_zero, b0.out_select, b0.out_shift};
    wire [12:0] r1 = {b1.out_sign, b1.out_zero, b1.out_select, b1.out_shift};
    wire [3:0]  hs = {b0.in_ready, b0.out_valid, b1.in_ready, b1.out_valid};

    localparam logic [12:0] E_4C    = {1'b0, 2'b00, 6'b000_001, 4'b10_10};
    localparam logic [12:0] E_0F    = {1'b0, 2'b10, 6'b000_111, 4'b00_00};
    localparam logic [12:0] E_B4_U  = {1'b0, 2'b00, 6'b101_000, 4'b00_10};
    localparam logic [12:0] E_B4_S  = {1'b1, 2'b00, 6'b000_001, 4'b10_10};
    localparam logic [12:0] E_80_U  = {1'b0, 2'b01, 6'b000_000, 4'b11_00};
    localparam logic [12:0] E_80_S  = {1'b1, 2'b01, 6'b000_000, 4'b11_00};
    localparam logic [12:0] E_PART  = {1'b0, 2'b00, 6'b000_001, 4'b00_10};

    // Accept c at the next edge, then wait (bounded) for out_valid; returns clocks from accept.
    task automatic xact(input logic [7:0] c, output int lat);
        in_valid  = 1'b1;
        coef      = c;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!b0.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (r0 !== 13'd0 || r1 !== 13'd0) begin bad++; $display("FAIL reset_fields got=%h/%h exp=0", r0, r1); end
        total++; if (hs !== 4'b1010) begin bad++; $display("FAIL reset_hs got=%b exp=1010", hs); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (hs !== 4'b1010 || r0 !== 13'd0) begin bad++; $display("FAIL post_reset got hs=%b r0=%h exp hs=1010 r0=0", hs, r0); end
    endtask

    task automatic test_basic_4c();
        int lat;
        xact(8'h4C, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL t1_latency got=%0d exp=2", lat); end
        total++; if (r0 !== E_4C) begin bad++; $display("FAIL t1_u0 got=%b exp=%b", r0, E_4C); end
        total++; if (r1 !== E_4C) begin bad++; $display("FAIL t1_u1 got=%b exp=%b", r1, E_4C); end
        total++; if (hs !== 4'b0101) begin bad++; $display("FAIL t1_hs got=%b exp=0101", hs); end
        release_out();
        total++; if (hs !== 4'b1010) begin bad++; $display("FAIL t1_release got=%b exp=1010", hs); end
    endtask

    task automatic test_zero_group();
        int lat;
        xact(8'h0F, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL t2_latency got=%0d exp=2", lat); end
        total++; if (r0 !== E_0F) begin bad++; $display("FAIL t2_u0 got=%b exp=%b", r0, E_0F); end
        total++; if (r1 !== E_0F) begin bad++; $display("FAIL t2_u1 got=%b exp=%b", r1, E_0F); end
        release_out();
    endtask

    task automatic test_signed_neg();
        int lat;
        xact(8'hB4, lat);
        total++; if (r1 !== E_B4_S) begin bad++; $display("FAIL t3_signed got=%b exp=%b", r1, E_B4_S); end
        total++; if (r0 !== E_B4_U) begin bad++; $display("FAIL t3_unsigned got=%b exp=%b", r0, E_B4_U); end
        release_out();
    endtask

    task automatic test_most_negative();
        int lat;
        xact(8'h80, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL t4_latency got=%0d exp=2", lat); end
        total++; if (r1 !== E_80_S) begin bad++; $display("FAIL t4_signed got=%b exp=%b", r1, E_80_S); end
        total++; if (r0 !== E_80_U) begin bad++; $display("FAIL t4_unsigned got=%b exp=%b", r0, E_80_U); end
        release_out();
    endtask

    task automatic test_stall_back_to_back();
        int lat;
        xact(8'h4C, lat);
        in_valid = 1'b1;
        coef     = 8'h0F;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total++; if (hs !== 4'b0101) begin bad++; $display("FAIL t5_stall_hs cyc=%0d got=%b exp=0101", k, hs); end
            total++; if (r0 !== E_4C || r1 !== E_4C) begin bad++; $display("FAIL t5_stall_data cyc=%0d got=%h/%h exp=%h", k, r0, r1, E_4C); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (hs !== 4'b1010) begin bad++; $display("FAIL t5_drop got=%b exp=1010", hs); end
        total++; if (r0 !== E_4C) begin bad++; $display("FAIL t5_hold_idle got=%b exp=%b", r0, E_4C); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (hs !== 4'b0000 || r0 !== 13'd0) begin bad++; $display("FAIL t5_accept got hs=%b r0=%h exp hs=0000 r0=0", hs, r0); end
        lat = 0;
        while (!b0.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 2 || r0 !== E_0F) begin bad++; $display("FAIL t5_next got lat=%0d r0=%b exp lat=2 r0=%b", lat, r0, E_0F); end
        release_out();
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        in_valid = 1'b1;
        coef     = 8'h4C;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (r0 !== E_PART || hs !== 4'b0000) begin bad++; $display("FAIL t6_partial got r0=%b hs=%b exp r0=%b hs=0000", r0, hs, E_PART); end
        #2 reset = 1'b1;
        #1;
        total++; if (r0 !== 13'd0 || r1 !== 13'd0) begin bad++; $display("FAIL t6_async_clear got=%h/%h exp=0", r0, r1); end
        total++; if (hs !== 4'b1010) begin bad++; $display("FAIL t6_async_hs got=%b exp=1010", hs); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (hs !== 4'b1010 || r0 !== 13'd0) begin bad++; $display("FAIL t6_after got hs=%b r0=%h exp hs=1010 r0=0", hs, r0); end
        xact(8'h4C, lat);
        total++; if (lat !== 2 || r0 !== E_4C || r1 !== E_4C) begin bad++; $display("FAIL t6_fresh got lat=%0d r0=%b r1=%b exp lat=2 %b", lat, r0, r1, E_4C); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_basic_4c();
        test_zero_group();
        test_signed_neg();
        test_most_negative();
        test_stall_back_to_back();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
